norm_round: RTL and testbench
=============================

NORM_ROUND -- requirements
Module: norm_round

Interface
REQ-001 SHALL have parameters: EXP_W, default 11, exponent width; FS_W, default 57, significand-sum width.
REQ-002 SHALL have ports: clk input 1 clock; rst input 1 reset (one clock; reset is synchronous and active-high).
REQ-003 SHALL have ports: in_valid input 1; in_ready output 1; fs input 57, magnitude sum from the sigadd stage (fs[56] carry, fs[55] hidden, fs[54:3] fraction, fs[2:0] guard/round/sticky); fszero input 1; ss1 input 1, result sign; es input 11, biased exponent of the larger operand (subnormal presented as 1); rm input 2, rounding mode.
REQ-004 SHALL have ports: out_valid output 1; out_ready input 1; result output 64, IEEE-754 binary64; flags output 3, {inexact, overflow, underflow}.

Function
REQ-005 SHALL be a 2-stage pipeline: S1 normalize, S2 round/pack; latency 2 cycles from accepted input to out_valid with no stall.
REQ-006 SHALL accept input on in_valid & in_ready; in_ready = ~s1_valid | s1_adv; s1_adv = ~s2_valid | out_ready; S2 loads when s1_valid & s1_adv.
REQ-007 SHALL hold result/flags/out_valid stable while out_valid & ~out_ready; no drop or reorder; full throughput 1/cycle when out_ready=1.
REQ-008 S1, fs[56]=1: right shift 1, shifted-out bit ORed into sticky, exponent = es+1.
REQ-009 S1, fs[56]=0: left shift by min(lzc(fs[55:0]), es-1); exponent = es - shift; exponent field 0 if hidden bit still 0 (subnormal).
REQ-010 S2 SHALL round on guard/round/sticky: rm 00 RNE (ties to even), 01 RTZ, 10 RUP (+inf), 11 RDN (-inf); signed by ss1.
REQ-011 Round carry out of the hidden bit SHALL increment exponent and keep fraction 0; subnormal rounding into hidden bit SHALL give exponent field 1.
REQ-012 Exponent >= 2047 SHALL give overflow: RNE → ±inf; RTZ → ±max finite; RUP → +inf / -max finite; RDN → -inf / +max finite; sets overflow and inexact.
REQ-013 fszero=1 SHALL give exact zero: +0 except rm=RDN → -0; flags 0.
REQ-014 inexact = any GRS bit set (or overflow); underflow = result tiny (exponent field 0 before rounding) and inexact.
REQ-015 Internal exponent SHALL be 13-bit signed to hold es+1 and es-lzc without wrap.

Reset
REQ-016 On rst: s1_valid, s2_valid, out_valid = 0; result = 0; flags = 0; in_ready = 1 the cycle after rst deasserts.
REQ-017 rst mid-operation SHALL discard all in-flight data; nothing emitted for it afterward.

Configuration
REQ-018 Macro NORM_ROUND_FLAGS_EN defined: flags computed per REQ-012..014, aligned with result.
REQ-019 Macro undefined: flags tied 3'b000, flag logic absent; result unchanged.

Structure
REQ-020 Package fpu_pkg SHALL hold: rounding-mode enum (RNE, RTZ, RUP, RDN), EXP_BIAS=1023, EXP_MAX=2047, FRAC_W=52, flag-bit indices.
REQ-021 One sub-module lzc56 (leading-zero counter, 56-bit in, 6-bit count, all-zero flag), instantiated in S1.

Verification
REQ-022 fs={0,1,55'b0}, es=0x3FF, ss1=0, rm=RNE → result 0x3FF0000000000000 two cycles later, flags 000.
REQ-023 fs={1,56'b0}, es=0x3FF → 0x4000000000000000; same fs with es=0x7FE, rm=RNE → 0x7FF0000000000000, flags 110; rm=RTZ → 0x7FEFFFFFFFFFFFFF.
REQ-024 fs={0,1,51'b0,1,3'b100}, rm=RNE → 0x3FF0000000000002 flags 100; fraction LSB 0 with GRS=100 → 0x3FF0000000000000.
REQ-025 fszero=1: rm=RDN → 0x8000000000000000; rm=RNE → 0x0000000000000000.
REQ-026 out_ready=0 for 4 cycles, 3 inputs offered: 2 accepted, in_ready=0 then, all 3 emitted in order once out_ready=1; rst pulse with 2 in flight → out_valid stays 0.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared definitions for the binary64 normalize/round datapath.
//   rm_e          : rounding-mode encoding as presented on the rm port
//   EXP_BIAS      : binary64 exponent bias
//   EXP_MAX       : all-ones exponent field (inf/NaN), first overflowing value
//   FRAC_W        : stored fraction width
//   FLAG_*        : bit positions inside the {inexact, overflow, underflow} vector
//   round_inc()   : decides whether the kept significand is incremented
package fpu_pkg;

    typedef enum logic [1:0] {
        RNE = 2'b00,
        RTZ = 2'b01,
        RUP = 2'b10,
        RDN = 2'b11
    } rm_e;

    localparam int EXP_BIAS       = 32'd1023;
    localparam int EXP_MAX        = 32'd2047;
    localparam int FRAC_W         = 32'd52;
    localparam int FLAG_INEXACT   = 32'd2;
    localparam int FLAG_OVERFLOW  = 32'd1;
    localparam int FLAG_UNDERFLOW = 32'd0;

    // Increment decision from the kept LSB and the guard/round/sticky bits.
    function automatic logic round_inc(input rm_e rm, input logic sign, input logic lsb,
                                       input logic g, input logic r, input logic s);
        logic inc_s;
        case (rm)
            RNE:     inc_s = g & (r | s | lsb);
            RTZ:     inc_s = 1'b0;
            RUP:     inc_s = ~sign & (g | r | s);
            RDN:     inc_s = sign & (g | r | s);
            default: inc_s = 1'b0;
        endcase
        return inc_s;
    endfunction

endpackage

// File: rtl/lzc56.sv
// lzc56: leading-zero counter for the 56-bit normalization window.
//   a    : input vector, bit 55 is the most significant
//   cnt  : number of leading zeros (56 when a is all zero)
//   zero : a is all zero
module lzc56 (
    input  logic [55:0] a,
    output logic [5:0]  cnt,
    output logic        zero
);

    logic       found_s;
    logic [5:0] cnt_s;

    // Scan from the MSB, counting zeros until the first set bit.
    always_comb begin
        found_s = 1'b0;
        cnt_s   = 6'd0;
        for (int i = 55; i >= 0; i--) begin
            if (!found_s) begin
                if (a[i]) begin
                    found_s = 1'b1;
                end else begin
                    cnt_s = cnt_s + 6'd1;
                end
            end else begin
                found_s = 1'b1;
            end
        end
    end

    assign cnt  = cnt_s;
    assign zero = ~found_s;

endmodule

// File: rtl/norm_round.sv
// norm_round: two-stage normalize (S1) and round/pack (S2) for an IEEE-754
// binary64 adder back end, with valid/ready flow control on both sides.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake
//   fs                   : magnitude sum {carry, hidden, fraction[51:0], G, R, S}
//   fszero               : exact-zero sum
//   ss1                  : result sign
//   es                   : biased exponent of the larger operand (subnormal as 1)
//   rm                   : rounding mode (see fpu_pkg::rm_e)
//   out_valid / out_ready: output handshake
//   result               : packed binary64 result
//   flags                : {inexact, overflow, underflow}
// Build option: NORM_ROUND_FLAGS_EN enables the flag logic; without it
// flags is tied to zero and result is unaffected.
module norm_round
    import fpu_pkg::*;
#(
    parameter int EXP_W = 32'd11,
    parameter int FS_W  = 32'd57
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FS_W-1:0]  fs,
    input  logic             fszero,
    input  logic             ss1,
    input  logic [EXP_W-1:0] es,
    input  logic [1:0]       rm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      result,
    output logic [2:0]       flags
);

    // ---------------- handshake ----------------
    logic s1_valid_r;
    logic s2_valid_r;
    logic s1_adv_s;

    assign s1_adv_s  = ~s2_valid_r | out_ready;
    assign in_ready  = ~s1_valid_r | s1_adv_s;
    assign out_valid = s2_valid_r;

    // ---------------- S1: normalize ----------------
    logic [5:0]         lz_s;
    logic               lz_zero_s;
    logic signed [12:0] es_x_s;
    logic signed [12:0] lim_s;
    logic signed [12:0] exp_n_s;
    logic [5:0]         shift_s;
    logic [55:0]        mant_n_s;

    lzc56 u_lzc (
        .a    (fs[55:0]),
        .cnt  (lz_s),
        .zero (lz_zero_s)
    );

    // Normalize: one-bit right shift on carry, otherwise left shift limited so
    // the exponent never drops below 1 (a result left with hidden=0 is subnormal).
    always_comb begin
        es_x_s = $signed({2'b00, es});
        lim_s  = es_x_s - 13'sd1;
        if (lz_zero_s || (es_x_s <= 13'sd1)) begin
            shift_s = 6'd0;
        end else if ($signed({7'd0, lz_s}) < lim_s) begin
            shift_s = lz_s;
        end else begin
            shift_s = lim_s[5:0];
        end
        if (fs[56]) begin
            // Bits shifted past S collapse into the new sticky bit.
            mant_n_s = {fs[56:2], fs[1] | fs[0]};
            exp_n_s  = es_x_s + 13'sd1;
        end else begin
            mant_n_s = fs[55:0] << shift_s;
            exp_n_s  = es_x_s - $signed({7'd0, shift_s});
        end
    end

    logic [55:0]        s1_mant_r;
    logic signed [12:0] s1_exp_r;
    logic               s1_sign_r;
    rm_e                s1_rm_r;
    logic               s1_zero_r;

    // Stage-1 register: takes a new operand whenever the stage can accept one.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_mant_r  <= 56'd0;
            s1_exp_r   <= 13'sd0;
            s1_sign_r  <= 1'b0;
            s1_rm_r    <= RNE;
            s1_zero_r  <= 1'b0;
        end else if (in_ready) begin
            s1_valid_r <= in_valid;
            s1_mant_r  <= mant_n_s;
            s1_exp_r   <= exp_n_s;
            s1_sign_r  <= ss1;
            s1_rm_r    <= rm_e'(rm);
            s1_zero_r  <= fszero;
        end
    end

    // ---------------- S2: round and pack ----------------
    logic               inc_s;
    logic [53:0]        sig_s;
    logic               tiny_s;
    logic signed [12:0] exp_r_s;
    logic [FRAC_W-1:0]  frac_s;
    logic               ovf_s;
    logic               to_inf_s;
    logic [63:0]        res_s;

    // Round the 53-bit significand and resolve carry, subnormal and overflow packing.
    always_comb begin
        inc_s  = round_inc(s1_rm_r, s1_sign_r, s1_mant_r[3], s1_mant_r[2],
                           s1_mant_r[1], s1_mant_r[0]);
        sig_s  = {1'b0, s1_mant_r[55:3]} + {53'd0, inc_s};
        tiny_s = ~s1_mant_r[55];
        if (sig_s[53]) begin
            // All-ones significand rounded up: renormalize, fraction becomes zero.
            exp_r_s = s1_exp_r + 13'sd1;
            frac_s  = 52'd0;
        end else if (sig_s[52]) begin
            // A subnormal that rounded into the hidden bit becomes the smallest normal.
            exp_r_s = tiny_s ? 13'sd1 : s1_exp_r;
            frac_s  = sig_s[51:0];
        end else begin
            exp_r_s = 13'sd0;
            frac_s  = sig_s[51:0];
        end
        ovf_s = (exp_r_s >= $signed(13'(EXP_MAX)));
        case (s1_rm_r)
            RNE:     to_inf_s = 1'b1;
            RTZ:     to_inf_s = 1'b0;
            RUP:     to_inf_s = ~s1_sign_r;
            RDN:     to_inf_s = s1_sign_r;
            default: to_inf_s = 1'b1;
        endcase
        if (s1_zero_r) begin
            res_s = {s1_rm_r == RDN, 63'd0};
        end else if (ovf_s) begin
            res_s = to_inf_s ? {s1_sign_r, 11'h7FF, 52'd0}
                             : {s1_sign_r, 11'h7FE, {52{1'b1}}};
        end else begin
            res_s = {s1_sign_r, exp_r_s[10:0], frac_s};
        end
    end

    logic [63:0] result_r;

    // Stage-2 register: loads when S1 holds data and the output slot is free.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            result_r   <= 64'd0;
        end else if (s1_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                result_r <= res_s;
            end
        end
    end

    assign result = result_r;

`ifdef NORM_ROUND_FLAGS_EN
    logic [2:0] flags_s;
    logic [2:0] flags_r;
    logic       grs_any_s;

    // Exception flags; an exact zero raises nothing.
    always_comb begin
        grs_any_s = |s1_mant_r[2:0];
        flags_s   = 3'b000;
        if (s1_zero_r) begin
            flags_s = 3'b000;
        end else begin
            flags_s[FLAG_INEXACT]   = grs_any_s | ovf_s;
            flags_s[FLAG_OVERFLOW]  = ovf_s;
            flags_s[FLAG_UNDERFLOW] = tiny_s & grs_any_s;
        end
    end

    // Flag register, loaded alongside result so the two stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_r <= 3'b000;
        end else if (s1_adv_s && s1_valid_r) begin
            flags_r <= flags_s;
        end
    end

    assign flags = flags_r;
`else
    assign flags = 3'b000;
`endif

endmodule

// File: tb/tb_norm_round.sv
// Self-checking bench for norm_round: directed vector table, hand-written
// stall/reset sequences and randomized traffic against an exact-arithmetic
// reference model. Honours NORM_ROUND_FLAGS_EN for the expected flags.
module tb_norm_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [56:0] fs;
    logic        fszero;
    logic        ss1;
    logic [10:0] es;
    logic [1:0]  rm;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic [2:0]  flags;

    always #5 clk = ~clk;

    norm_round dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fs        (fs),
        .fszero    (fszero),
        .ss1       (ss1),
        .es        (es),
        .rm        (rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    typedef struct {
        logic [56:0] fs;
        logic        z;
        logic        sg;
        logic [10:0] e;
        logic [1:0]  m;
        logic [63:0] res;
        logic [2:0]  flg;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic [2:0]  flg;
    } exp_t;

    vec_t        tbl[$];
    exp_t        exp_q[$];
    exp_t        cur_exp;
    int          checks = 0;
    int          errors = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_res;
    logic [2:0]  prev_flg;

    function automatic logic [2:0] fl(input logic [2:0] f);
`ifdef NORM_ROUND_FLAGS_EN
        return f;
`else
        return f & 3'b000;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Exact reference: locate leading one, pick target exponent, divide off the
    // dropped bits and round on the exact remainder.
    function automatic exp_t ref_model(input logic [56:0] f, input logic z, input logic sg,
                                       input logic [10:0] e, input logic [1:0] m);
        exp_t        r;
        logic [63:0] f64, mm, rem, half;
        int          p, ee, k, field;
        logic        inexact, tiny, inc, ovf, to_inf;
        r.flg = 3'b000;
        if (z) begin
            r.res = {(m == 2'b11), 63'd0};
            return r;
        end
        f64 = {7'd0, f};
        p = -1;
        for (int i = 0; i < 57; i++) if (f[i]) p = i;
        if (p < 0) begin
            r.res = {sg, 63'd0};
            return r;
        end
        ee = int'(e) + p - 55;
        if (ee < 1) ee = 1;
        k = ee - int'(e) + 3;
        if (k > 0) begin
            mm   = f64 >> k;
            rem  = f64 & ((64'd1 << k) - 64'd1);
            half = 64'd1 << (k - 1);
        end else begin
            mm   = f64 << (-k);
            rem  = 64'd0;
            half = 64'd0;
        end
        inexact = (rem != 64'd0);
        tiny    = (mm < (64'd1 << 52));
        case (m)
            2'b00:   inc = inexact && ((rem > half) || (rem == half && mm[0]));
            2'b01:   inc = 1'b0;
            2'b10:   inc = inexact && !sg;
            default: inc = inexact && sg;
        endcase
        mm = mm + {63'd0, inc};
        if (mm >= (64'd1 << 53)) begin
            mm = mm >> 1;
            ee++;
        end
        field = (mm >= (64'd1 << 52)) ? ee : 0;
        ovf = (field >= 2047);
        if (ovf) begin
            to_inf = (m == 2'b00) || (m == 2'b10 && !sg) || (m == 2'b11 && sg);
            r.res  = to_inf ? {sg, 11'h7FF, 52'd0} : {sg, 11'h7FE, {52{1'b1}}};
        end else begin
            r.res  = {sg, field[10:0], mm[51:0]};
        end
        r.flg = fl({inexact || ovf, ovf, tiny && inexact});
        return r;
    endfunction

    task automatic drive(input logic [56:0] f, input logic z, input logic sg,
                         input logic [10:0] e, input logic [1:0] m, input exp_t ex);
        fs = f; fszero = z; ss1 = sg; es = e; rm = m;
        cur_exp = ex;
        in_valid = 1'b1;
    endtask

    task automatic drive_vec(input vec_t v);
        exp_t ex;
        ex.res = v.res;
        ex.flg = fl(v.flg);
        drive(v.fs, v.z, v.sg, v.e, v.m, ex);
    endtask

    // One clock: observe handshakes at the sampling point, then advance.
    task automatic step(output logic acc);
        logic take;
        exp_t e;
        #1;
        acc  = in_valid & in_ready;
        take = out_valid & out_ready;
        if (prev_stall) begin
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_result", result, prev_res);
            chk("hold_flags", {61'd0, flags}, {61'd0, prev_flg});
        end
        prev_stall = out_valid & ~out_ready;
        prev_res   = result;
        prev_flg   = flags;
        if (take) begin
            if (exp_q.size() == 0) begin
                chk("spurious_output", {63'd0, out_valid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result", result, e.res);
                chk("flags", {61'd0, flags}, {61'd0, e.flg});
            end
        end
        if (acc) exp_q.push_back(cur_exp);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        logic acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(acc);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic add(input logic [56:0] f, input logic z, input logic sg, input logic [10:0] e,
                       input logic [1:0] m, input logic [63:0] res, input logic [2:0] flg);
        vec_t v;
        v.fs = f; v.z = z; v.sg = sg; v.e = e; v.m = m; v.res = res; v.flg = flg;
        tbl.push_back(v);
    endtask

    initial begin
        logic        acc;
        int          acc_cnt;
        int          sent;
        logic [63:0] rnd;
        logic [56:0] rf;
        logic [10:0] re;
        logic        rz, rs;
        logic [1:0]  rmode;

        add({1'b0, 1'b1, 55'd0},                   1'b0, 1'b0, 11'h3FF, 2'b00, 64'h3FF0000000000000, 3'b000);
        add({1'b1, 56'd0},                         1'b0, 1'b0, 11'h3FF, 2'b00, 64'h4000000000000000, 3'b000);
        add({1'b1, 56'd0},                         1'b0, 1'b0, 11'h7FE, 2'b00, 64'h7FF0000000000000, 3'b110);
        add({1'b1, 56'd0},                         1'b0, 1'b0, 11'h7FE, 2'b01, 64'h7FEFFFFFFFFFFFFF, 3'b110);
        add({1'b1, 56'd0},                         1'b0, 1'b1, 11'h7FE, 2'b10, 64'hFFEFFFFFFFFFFFFF, 3'b110);
        add({1'b1, 56'd0},                         1'b0, 1'b1, 11'h7FE, 2'b11, 64'hFFF0000000000000, 3'b110);
        add({1'b0, 1'b1, 51'd0, 1'b1, 3'b100},     1'b0, 1'b0, 11'h3FF, 2'b00, 64'h3FF0000000000002, 3'b100);
        add({1'b0, 1'b1, 52'd0, 3'b100},           1'b0, 1'b0, 11'h3FF, 2'b00, 64'h3FF0000000000000, 3'b100);
        add(57'd0,                                 1'b1, 1'b0, 11'h3FF, 2'b11, 64'h8000000000000000, 3'b000);
        add(57'd0,                                 1'b1, 1'b1, 11'h3FF, 2'b00, 64'h0000000000000000, 3'b000);
        add({2'b00, 1'b1, 54'd0},                  1'b0, 1'b0, 11'h001, 2'b00, 64'h0008000000000000, 3'b000);
        add({2'b00, {52{1'b1}}, 3'b100},           1'b0, 1'b0, 11'h001, 2'b00, 64'h0010000000000000, 3'b101);
        add({1'b0, 1'b1, {52{1'b1}}, 3'b100},      1'b0, 1'b0, 11'h3FF, 2'b00, 64'h4000000000000000, 3'b100);
        add({2'b01, 52'd0, 3'b001},                1'b0, 1'b0, 11'h3FF, 2'b10, 64'h3FF0000000000001, 3'b100);
        add({2'b01, 52'd0, 3'b001},                1'b0, 1'b1, 11'h3FF, 2'b11, 64'hBFF0000000000001, 3'b100);
        add({2'b01, 52'd0, 3'b001},                1'b0, 1'b1, 11'h3FF, 2'b01, 64'hBFF0000000000000, 3'b100);
        add({2'b01, 52'd0, 3'b001},                1'b0, 1'b0, 11'h3FF, 2'b00, 64'h3FF0000000000000, 3'b100);
        add({3'b000, 1'b1, 53'd0},                 1'b0, 1'b0, 11'h400, 2'b00, 64'h3FE0000000000000, 3'b000);
        add({1'b1, 52'd0, 4'b1000},                1'b0, 1'b0, 11'h3FF, 2'b00, 64'h4000000000000000, 3'b100);
        add({1'b1, 52'd0, 4'b1001},                1'b0, 1'b0, 11'h3FF, 2'b00, 64'h4000000000000001, 3'b100);

        // Reset state
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        fs = 57'd0; fszero = 1'b0; ss1 = 1'b0; es = 11'd0; rm = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_flags", {61'd0, flags}, 64'd0);
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Two-cycle latency
        drive_vec(tbl[0]);
        step(acc);
        in_valid = 1'b0;
        chk("latency_1", {63'd0, out_valid}, 64'd0);
        step(acc);
        chk("latency_2", {63'd0, out_valid}, 64'd1);
        drain();

        // Directed table, back to back at full rate
        for (int i = 0; i < tbl.size(); i++) begin
            drive_vec(tbl[i]);
            step(acc);
            chk("tbl_accept", {63'd0, acc}, 64'd1);
        end
        drain();

        // Stall: three offered while out_ready is low, only two fit
        out_ready = 1'b0;
        acc_cnt = 0;
        drive_vec(tbl[1]);
        for (int i = 0; i < 4; i++) begin
            step(acc);
            if (acc) begin
                acc_cnt++;
                drive_vec(tbl[(acc_cnt == 1) ? 6 : 13]);
            end
        end
        chk("stall_accepted", 64'(acc_cnt), 64'd2);
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) step(acc);
        chk("stall_third_accept", {63'd0, acc}, 64'd1);
        drain();

        // Reset with two operands in flight
        out_ready = 1'b0;
        drive_vec(tbl[0]);
        step(acc);
        drive_vec(tbl[1]);
        step(acc);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        prev_stall = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
            @(negedge clk);
        end

        // Randomized traffic against the reference model
        sent = 0;
        for (int cyc = 0; cyc < 4000 && sent < 400; cyc++) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                rnd = {$urandom, $urandom};
                rf  = rnd[56:0] >> $urandom_range(0, 56);
                if (rf == 57'd0) rf = 57'd1;
                case ($urandom_range(0, 3))
                    0:       re = 11'($urandom_range(1, 4));
                    1:       re = 11'($urandom_range(2040, 2046));
                    default: re = 11'($urandom_range(1, 2046));
                endcase
                rz    = ($urandom_range(0, 9) == 0);
                rs    = 1'($urandom_range(0, 1));
                rmode = 2'($urandom_range(0, 3));
                drive(rf, rz, rs, re, rmode, ref_model(rf, rz, rs, re, rmode));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step(acc);
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        chk("random_sent", 64'(sent), 64'd400);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
